// File: rtl/pkt_rr_arbiter.sv
// Packet-aware round-robin input arbiter.
// Each rx port feeds its own store-and-forward FIFO. A port becomes eligible
// once it holds at least one complete packet and is enabled in port_en. The
// arbiter grants one packet at a time, streams it out, and then enforces an
// inter-frame gap before the next grant.
module pkt_rr_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int NUM_PORTS  = 4,
    parameter int PORT_W     = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1,
    parameter int FIFO_DEPTH = 32,
    parameter int AF_MARGIN  = 4,
    parameter int IFG_CYCLES = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  in_data,
    input  logic [NUM_PORTS*CTRL_WIDTH-1:0]  in_ctrl,
    input  logic [NUM_PORTS-1:0]             in_wr,
    input  logic [NUM_PORTS-1:0]             in_last,
    output logic [NUM_PORTS-1:0]             in_rdy,
    input  logic [NUM_PORTS-1:0]             port_en,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [CTRL_WIDTH-1:0]            out_ctrl,
    output logic                             out_wr,
    output logic                             out_sop,
    output logic                             out_eop,
    output logic [PORT_W-1:0]                out_port,
    input  logic                             out_rdy,
    output logic [NUM_PORTS-1:0]             drop_err
);

    localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW     = AW + 1;
    localparam int WORD_W = 1 + CTRL_WIDTH + DATA_WIDTH;
    localparam int IFG_W  = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_IFG  = 2'd2
    } state_t;

    // Buffer storage and per-port bookkeeping
    logic [WORD_W-1:0]     r_mem      [NUM_PORTS][FIFO_DEPTH];
    logic [CW-1:0]         r_wptr     [NUM_PORTS];
    logic [CW-1:0]         r_rptr     [NUM_PORTS];
    logic [CW-1:0]         r_pkt_cnt  [NUM_PORTS];
    logic [NUM_PORTS-1:0]  r_in_rdy;
    logic [NUM_PORTS-1:0]  r_drop_err;

    // Arbiter / output state
    state_t                r_state;
    logic [PORT_W-1:0]     r_cur_port;
    logic [PORT_W-1:0]     r_last_grant;
    logic                  r_sop_pend;
    logic [IFG_W-1:0]      r_ifg_cnt;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [CTRL_WIDTH-1:0] r_out_ctrl;
    logic                  r_out_wr;
    logic                  r_out_sop;
    logic                  r_out_eop;
    logic [PORT_W-1:0]     r_out_port;

    // Combinational helpers
    logic [CW-1:0]         w_count    [NUM_PORTS];
    logic [CW-1:0]         w_wptr_nxt [NUM_PORTS];
    logic [CW-1:0]         w_rptr_nxt [NUM_PORTS];
    logic [CW-1:0]         w_free_nxt [NUM_PORTS];
    logic [NUM_PORTS-1:0]  w_full;
    logic [NUM_PORTS-1:0]  w_empty;
    logic [NUM_PORTS-1:0]  w_push;
    logic [NUM_PORTS-1:0]  w_pop;
    logic [NUM_PORTS-1:0]  w_push_last;
    logic [NUM_PORTS-1:0]  w_pop_last;
    logic [NUM_PORTS-1:0]  w_eligible;
    logic [WORD_W-1:0]     w_head;
    logic                  w_head_last;
    logic                  w_pop_any;
    logic                  w_grant_vld;
    logic [PORT_W-1:0]     w_grant_port;
    logic [PORT_W-1:0]     w_idx;
    logic                  w_hit;

    // Fill level, full/empty, accepted writes and eligibility per port
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_count[p]    = r_wptr[p] - r_rptr[p];
            w_full[p]     = (w_count[p] == CW'(FIFO_DEPTH));
            w_empty[p]    = (w_count[p] == {CW{1'b0}});
            w_push[p]     = in_wr[p] & ~w_full[p];
            w_eligible[p] = port_en[p] & (r_pkt_cnt[p] != {CW{1'b0}});
        end
    end

    // Head-of-line word of the granted port (first-word-fall-through) and pop decision
    always_comb begin
        w_head      = r_mem[r_cur_port][r_rptr[r_cur_port][AW-1:0]];
        w_head_last = w_head[WORD_W-1];
        w_pop_any   = (r_state == S_XFER) && out_rdy && !w_empty[r_cur_port];
    end

    // Per-port pointer advance, packet-boundary events and post-update free space
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_pop[p]       = w_pop_any && (r_cur_port == PORT_W'(p));
            w_push_last[p] = w_push[p] & in_last[p];
            w_pop_last[p]  = w_pop[p] & w_head_last;
            w_wptr_nxt[p]  = w_push[p] ? (r_wptr[p] + CW'(1)) : r_wptr[p];
            w_rptr_nxt[p]  = w_pop[p]  ? (r_rptr[p] + CW'(1)) : r_rptr[p];
            w_free_nxt[p]  = CW'(FIFO_DEPTH) - (w_wptr_nxt[p] - w_rptr_nxt[p]);
        end
    end

    // Round-robin search from last_grant+1 with wrap; the whole scan resolves in one cycle
    always_comb begin
        w_grant_vld  = 1'b0;
        w_grant_port = {PORT_W{1'b0}};
        w_idx        = {PORT_W{1'b0}};
        w_hit        = 1'b0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            w_idx        = PORT_W'((int'(r_last_grant) + k) % NUM_PORTS);
            w_hit        = !w_grant_vld && w_eligible[w_idx];
            w_grant_port = w_hit ? w_idx : w_grant_port;
            w_grant_vld  = w_grant_vld | w_hit;
        end
    end

    // Write accepted words into the buffers; contents are don't-care once the pointers clear
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_push[p]) begin
                r_mem[p][r_wptr[p][AW-1:0]] <= {in_last[p],
                                                in_ctrl[p*CTRL_WIDTH +: CTRL_WIDTH],
                                                in_data[p*DATA_WIDTH +: DATA_WIDTH]};
            end
        end
    end

    // Pointers, complete-packet counts, sticky drop flags and ready per port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_wptr[p]    <= {CW{1'b0}};
                r_rptr[p]    <= {CW{1'b0}};
                r_pkt_cnt[p] <= {CW{1'b0}};
            end
            r_in_rdy   <= {NUM_PORTS{1'b0}};
            r_drop_err <= {NUM_PORTS{1'b0}};
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_wptr[p]   <= w_wptr_nxt[p];
                r_rptr[p]   <= w_rptr_nxt[p];
                r_in_rdy[p] <= (w_free_nxt[p] > CW'(AF_MARGIN));
                if (w_push_last[p] && !w_pop_last[p]) begin
                    r_pkt_cnt[p] <= r_pkt_cnt[p] + CW'(1);
                end else if (!w_push_last[p] && w_pop_last[p]) begin
                    r_pkt_cnt[p] <= r_pkt_cnt[p] - CW'(1);
                end
                if (in_wr[p] && w_full[p]) begin
                    r_drop_err[p] <= 1'b1;
                end
            end
        end
    end

    // Grant / transfer / inter-frame-gap sequencer with registered output word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cur_port   <= {PORT_W{1'b0}};
            r_last_grant <= PORT_W'(NUM_PORTS - 1);
            r_sop_pend   <= 1'b0;
            r_ifg_cnt    <= {IFG_W{1'b0}};
            r_out_data   <= {DATA_WIDTH{1'b0}};
            r_out_ctrl   <= {CTRL_WIDTH{1'b0}};
            r_out_wr     <= 1'b0;
            r_out_sop    <= 1'b0;
            r_out_eop    <= 1'b0;
            r_out_port   <= {PORT_W{1'b0}};
        end else begin
            r_out_wr  <= 1'b0;
            r_out_sop <= 1'b0;
            r_out_eop <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_vld && out_rdy) begin
                        r_cur_port   <= w_grant_port;
                        r_last_grant <= w_grant_port;
                        r_sop_pend   <= 1'b1;
                        r_state      <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (w_pop_any) begin
                        r_out_wr   <= 1'b1;
                        r_out_data <= w_head[DATA_WIDTH-1:0];
                        r_out_ctrl <= w_head[DATA_WIDTH +: CTRL_WIDTH];
                        r_out_sop  <= r_sop_pend;
                        r_out_eop  <= w_head_last;
                        r_out_port <= r_cur_port;
                        r_sop_pend <= 1'b0;
                        if (w_head_last) begin
                            if (IFG_CYCLES > 0) begin
                                r_state   <= S_IFG;
                                r_ifg_cnt <= IFG_W'(1);
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end
                    end
                end
                S_IFG: begin
                    if (r_ifg_cnt >= IFG_W'(IFG_CYCLES)) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_ifg_cnt <= r_ifg_cnt + IFG_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_rdy   = r_in_rdy;
    assign drop_err = r_drop_err;
    assign out_data = r_out_data;
    assign out_ctrl = r_out_ctrl;
    assign out_wr   = r_out_wr;
    assign out_sop  = r_out_sop;
    assign out_eop  = r_out_eop;
    assign out_port = r_out_port;

endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Directed self-checking bench for pkt_rr_arbiter (4 ports, IFG of 4 cycles).
module tb_pkt_rr_arbiter;

    localparam int DW  = 64;
    localparam int CWD = 8;
    localparam int NP  = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [NP*DW-1:0]  in_data;
    logic [NP*CWD-1:0] in_ctrl;
    logic [NP-1:0]   in_wr;
    logic [NP-1:0]   in_last;
    logic [NP-1:0]   in_rdy;
    logic [NP-1:0]   port_en;
    logic [DW-1:0]   out_data;
    logic [CWD-1:0]  out_ctrl;
    logic            out_wr;
    logic            out_sop;
    logic            out_eop;
    logic [1:0]      out_port;
    logic            out_rdy;
    logic [NP-1:0]   drop_err;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int r0;

    typedef struct {
        int          cyc;
        logic [1:0]  port;
        logic        sop;
        logic        eop;
        logic [63:0] data;
    } rec_t;
    rec_t mq[$];

    pkt_rr_arbiter #(
        .DATA_WIDTH(DW), .CTRL_WIDTH(CWD), .NUM_PORTS(NP), .PORT_W(2),
        .FIFO_DEPTH(32), .AF_MARGIN(4), .IFG_CYCLES(4)
    ) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_ctrl(in_ctrl),
        .in_wr(in_wr), .in_last(in_last), .in_rdy(in_rdy), .port_en(port_en),
        .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr),
        .out_sop(out_sop), .out_eop(out_eop), .out_port(out_port),
        .out_rdy(out_rdy), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    // Cycle index: equals the number of rising edges seen so far
    always @(posedge clk) cyc <= cyc + 1;

    // Capture every output word on the falling edge, tagged with its cycle index
    always @(negedge clk) begin
        if (out_wr) begin
            rec_t r;
            r.cyc  = cyc;
            r.port = out_port;
            r.sop  = out_sop;
            r.eop  = out_eop;
            r.data = out_data;
            mq.push_back(r);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr_word(input logic [1:0] port, input logic [63:0] data, input logic last);
        int b;
        b = int'(port);
        in_wr[b]             = 1'b1;
        in_last[b]           = last;
        in_data[b*DW +: DW]  = data;
        in_ctrl[b*CWD +: CWD] = data[7:0];
        tick();
        in_wr[b]   = 1'b0;
        in_last[b] = 1'b0;
    endtask

    task automatic send_pkt(input logic [1:0] port, input int len, input logic [63:0] base);
        for (int w = 0; w < len; w++) begin
            wr_word(port, base + 64'(w), (w == len - 1));
        end
    endtask

    task automatic wait_words(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && mq.size() < n; i++) tick();
        tick();
        chk(tag, 64'(mq.size() >= n), 64'd1);
    endtask

    initial begin
        reset   = 1'b0;
        in_data = '0;
        in_ctrl = '0;
        in_wr   = 4'b0000;
        in_last = 4'b0000;
        port_en = 4'b1111;
        out_rdy = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_out_wr",   64'(out_wr),   64'd0);
        chk("rst_in_rdy",   64'(in_rdy),   64'd0);
        chk("rst_drop_err", 64'(drop_err), 64'd0);
        chk("rst_out_data", out_data,      64'd0);
        reset = 1'b1;
        repeat (2) tick();
        chk("rel_in_rdy", 64'(in_rdy), 64'hF);

        // Port0: two 3-word packets, latency and inter-frame gap
        send_pkt(2'd0, 3, 64'h0100);
        send_pkt(2'd0, 3, 64'h0110);
        repeat (5) tick();
        chk("t1_hold_no_out", 64'(mq.size()), 64'd0);
        mq.delete();
        out_rdy = 1'b1;
        r0 = cyc;
        wait_words("t1_count", 6, 60);
        repeat (10) tick();
        chk("t1_latency", 64'(mq[0].cyc - r0), 64'd2);
        chk("t1_w2_next", 64'(mq[1].cyc - mq[0].cyc), 64'd1);
        chk("t1_w3_next", 64'(mq[2].cyc - mq[1].cyc), 64'd1);
        chk("t1_sop", 64'({mq[0].sop, mq[1].sop, mq[2].sop}), 64'b100);
        chk("t1_eop", 64'({mq[0].eop, mq[1].eop, mq[2].eop}), 64'b001);
        chk("t1_port", 64'({mq[0].port, mq[1].port, mq[2].port}), 64'd0);
        chk("t1_d0", mq[0].data, 64'h0100);
        chk("t1_d2", mq[2].data, 64'h0102);
        chk("t1_gap", 64'(mq[3].cyc - mq[2].cyc), 64'd6);
        chk("t1_p2_sop", 64'(mq[3].sop), 64'd1);
        chk("t1_p2_d0", mq[3].data, 64'h0110);
        chk("t1_total", 64'(mq.size()), 64'd6);

        // Ports 1 and 3 round-robin with a second port1 packet waiting
        out_rdy = 1'b0;
        send_pkt(2'd1, 2, 64'h1100);
        send_pkt(2'd3, 2, 64'h3100);
        send_pkt(2'd1, 2, 64'h1200);
        mq.delete();
        out_rdy = 1'b1;
        wait_words("t2_count", 6, 80);
        repeat (10) tick();
        chk("t2_first_port", 64'(mq[0].port), 64'd1);
        chk("t2_first_data", mq[0].data, 64'h1100);
        chk("t2_second_port", 64'(mq[2].port), 64'd3);
        chk("t2_second_data", mq[2].data, 64'h3100);
        chk("t2_third_port", 64'(mq[4].port), 64'd1);
        chk("t2_third_data", mq[4].data, 64'h1200);
        chk("t2_gap_a", 64'(mq[2].cyc - mq[1].cyc), 64'd6);
        chk("t2_gap_b", 64'(mq[4].cyc - mq[3].cyc), 64'd6);

        // Port2: 4-word packet stalled for 3 cycles after word 1
        out_rdy = 1'b0;
        send_pkt(2'd2, 4, 64'h2100);
        mq.delete();
        out_rdy = 1'b1;
        r0 = cyc;
        tick();
        tick();
        out_rdy = 1'b0;
        repeat (3) tick();
        out_rdy = 1'b1;
        wait_words("t3_count", 4, 40);
        repeat (10) tick();
        chk("t3_total", 64'(mq.size()), 64'd4);
        chk("t3_t0", 64'(mq[0].cyc - r0), 64'd2);
        chk("t3_t1", 64'(mq[1].cyc - r0), 64'd6);
        chk("t3_t2", 64'(mq[2].cyc - r0), 64'd7);
        chk("t3_t3", 64'(mq[3].cyc - r0), 64'd8);
        for (int w = 0; w < 4; w++) begin
            chk($sformatf("t3_d%0d", w), mq[w].data, 64'h2100 + 64'(w));
        end
        chk("t3_sop", 64'({mq[0].sop, mq[1].sop, mq[2].sop, mq[3].sop}), 64'b1000);
        chk("t3_eop", 64'({mq[0].eop, mq[1].eop, mq[2].eop, mq[3].eop}), 64'b0001);

        // Incomplete packet on port2 must wait for its last word
        mq.delete();
        wr_word(2'd2, 64'h2200, 1'b0);
        wr_word(2'd2, 64'h2201, 1'b0);
        send_pkt(2'd0, 2, 64'h0200);
        repeat (20) tick();
        chk("t4_only_port0", 64'(mq.size()), 64'd2);
        chk("t4_port0", 64'({mq[0].port, mq[1].port}), 64'd0);
        wr_word(2'd2, 64'h2202, 1'b1);
        wait_words("t4_count", 5, 40);
        repeat (10) tick();
        chk("t4_total", 64'(mq.size()), 64'd5);
        chk("t4_p2_port", 64'(mq[2].port), 64'd2);
        chk("t4_p2_sop", 64'(mq[2].sop), 64'd1);
        chk("t4_p2_d0", mq[2].data, 64'h2200);
        chk("t4_p2_last", mq[4].data, 64'h2202);
        chk("t4_p2_eop", 64'(mq[4].eop), 64'd1);

        // Masked port0 buffers a 28-word packet; ready follows fill level
        port_en = 4'b1110;
        mq.delete();
        for (int w = 0; w < 27; w++) wr_word(2'd0, 64'h0300 + 64'(w), 1'b0);
        chk("t5_rdy_27", 64'(in_rdy[0]), 64'd1);
        wr_word(2'd0, 64'h031B, 1'b1);
        chk("t5_rdy_28", 64'(in_rdy[0]), 64'd0);
        repeat (20) tick();
        chk("t5_masked", 64'(mq.size()), 64'd0);
        port_en = 4'b1111;
        wait_words("t5_count", 28, 100);
        repeat (10) tick();
        chk("t5_total", 64'(mq.size()), 64'd28);
        chk("t5_port", 64'(mq[0].port), 64'd0);
        chk("t5_d0", mq[0].data, 64'h0300);
        chk("t5_dlast", mq[27].data, 64'h031B);
        chk("t5_eop", 64'(mq[27].eop), 64'd1);
        chk("t5_rdy_drained", 64'(in_rdy[0]), 64'd1);

        // Fill port1 to full, then overflow by one word
        port_en = 4'b1101;
        for (int w = 0; w < 27; w++) wr_word(2'd1, 64'h1300 + 64'(w), 1'b0);
        chk("t6_rdy_27", 64'(in_rdy[1]), 64'd1);
        wr_word(2'd1, 64'h131B, 1'b0);
        chk("t6_rdy_28", 64'(in_rdy[1]), 64'd0);
        for (int w = 28; w < 32; w++) wr_word(2'd1, 64'h1300 + 64'(w), 1'b0);
        chk("t6_full_no_drop", 64'(drop_err), 64'd0);
        wr_word(2'd1, 64'h1320, 1'b0);
        chk("t6_drop", 64'(drop_err), 64'b0010);
        repeat (5) tick();
        chk("t6_drop_sticky", 64'(drop_err), 64'b0010);

        // Reset pulse in the middle of a port3 transfer
        port_en = 4'b1111;
        mq.delete();
        send_pkt(2'd3, 4, 64'h3300);
        wait_words("t7_started", 1, 20);
        #2;
        reset = 1'b0;
        #1;
        chk("t7_rst_wr",   64'(out_wr),   64'd0);
        chk("t7_rst_sop",  64'(out_sop),  64'd0);
        chk("t7_rst_eop",  64'(out_eop),  64'd0);
        chk("t7_rst_port", 64'(out_port), 64'd0);
        chk("t7_rst_data", out_data,      64'd0);
        chk("t7_rst_ctrl", 64'(out_ctrl), 64'd0);
        chk("t7_rst_rdy",  64'(in_rdy),   64'd0);
        chk("t7_rst_drop", 64'(drop_err), 64'd0);
        tick();
        reset = 1'b1;
        mq.delete();
        repeat (20) tick();
        chk("t7_no_leftover", 64'(mq.size()), 64'd0);
        out_rdy = 1'b0;
        send_pkt(2'd2, 2, 64'h2400);
        send_pkt(2'd0, 2, 64'h0400);
        out_rdy = 1'b1;
        r0 = cyc;
        wait_words("t7_count", 4, 60);
        repeat (10) tick();
        chk("t7_first_port", 64'(mq[0].port), 64'd0);
        chk("t7_latency", 64'(mq[0].cyc - r0), 64'd2);
        chk("t7_first_data", mq[0].data, 64'h0400);
        chk("t7_second_port", 64'(mq[2].port), 64'd2);
        chk("t7_second_data", mq[2].data, 64'h2400);
        chk("t7_in_rdy", 64'(in_rdy), 64'hF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
